// File: rtl/ysyx_22040895_mem_rsp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040895_mem_rsp
// Brief    : Data-memory responder with programmable latency and byte-masked
//            writes. Define YSYX_22040895_MEM_RSP_RANGE_CHK_EN for range errors.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040895_mem_rsp #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         c_IDX_W    = $clog2(DEPTH);
   localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic               r_we;
   logic [c_IDX_W-1:0] r_idx;
   logic [63:0]        r_wdata;
   logic [7:0]         r_wmask;
   logic               r_oor;
   logic [63:0]        r_rdata;
   logic               r_err;
   logic               w_accept;
   logic               w_commit;
   logic               w_wr_en;
   logic               w_req_oor;
   logic               w_unused_addr;
   logic [63:0]        r_mem [DEPTH];

`ifdef YSYX_22040895_MEM_RSP_RANGE_CHK_EN
   // Any set bit above the index field places the access outside the array.
   assign w_req_oor     = |req_addr[63:c_IDX_W+3];
   assign w_unused_addr = ^req_addr[2:0];
`else
   assign w_req_oor     = 1'b0;
   assign w_unused_addr = ^{req_addr[63:c_IDX_W+3], req_addr[2:0]};
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) begin
               w_commit    = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign w_wr_en   = w_commit && r_we && !r_oor;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= 64'd0;
         r_wmask <= 8'd0;
         r_oor   <= 1'b0;
         r_rdata <= 64'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_we    <= req_we;
            r_idx   <= req_addr[c_IDX_W+2:3];
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            r_oor   <= w_req_oor;
            r_cnt   <= c_CNT_INIT;
         end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit) begin
            r_err <= r_oor;
            if (r_we || r_oor) begin
               r_rdata <= 64'd0;
            end else begin
               r_rdata <= r_mem[r_idx];
            end
         end
      end
   end

   // Storage is deliberately left out of reset so it maps onto RAM resources.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (r_wmask[i]) begin
               r_mem[r_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040895_mem_rsp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040895_mem_rsp
// Brief    : Self-checking bench for ysyx_22040895_mem_rsp against a byte model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040895_mem_rsp;

   localparam int DEPTH   = 1024;
   localparam int LATENCY = 3;
`ifdef YSYX_22040895_MEM_RSP_RANGE_CHK_EN
   localparam bit RCHK = 1'b1;
`else
   localparam bit RCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic [7:0]  req_wmask = 8'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference memory: one entry per byte address, absent means never written.
   logic [7:0] mdl [longint];

   always #5 clk = ~clk;

   ysyx_22040895_mem_rsp #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_oor(input logic [63:0] a);
      return RCHK && (a >= 64'(DEPTH) * 64'd8);
   endfunction

   function automatic longint wbase(input logic [63:0] a);
      return longint'((a >> 3) % 64'(DEPTH)) * 8;
   endfunction

   function automatic logic [63:0] mdl_word(input logic [63:0] a);
      logic [63:0] w;
      longint      b;
      b = wbase(a);
      for (int i = 0; i < 8; i++)
         w[i*8 +: 8] = mdl.exists(b + i) ? mdl[b + i] : 8'hxx;
      return w;
   endfunction

   function automatic void mdl_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
      longint b;
      b = wbase(a);
      for (int i = 0; i < 8; i++)
         if (m[i]) mdl[b + i] = d[i*8 +: 8];
   endfunction

   // One complete request/response exchange, holding off the response for 'hold' cycles.
   task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask,
                       input int hold, output logic [63:0] got);
      logic [63:0] exp_d;
      logic        exp_e;
      int          cyc;
      exp_e = is_oor(addr);
      exp_d = (we || exp_e) ? 64'd0 : mdl_word(addr);
      @(negedge clk);
      chk({tag, ":req_ready_idle"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = wmask;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (we && !exp_e) mdl_store(addr, wdata, wmask);
      cyc = 0;
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1 || cyc > 40) break;
         chk({tag, ":req_ready_busy"}, 64'(req_ready), 64'd0);
         cyc++;
      end
      chk({tag, ":latency"}, 64'(cyc), 64'(LATENCY));
      chk({tag, ":rdata"}, rsp_rdata, exp_d);
      chk({tag, ":err"}, 64'(rsp_err), 64'(exp_e));
      got = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, ":hold_valid"}, 64'(rsp_valid), 64'd1);
         chk({tag, ":hold_rdata"}, rsp_rdata, exp_d);
         chk({tag, ":hold_req_ready"}, 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, ":back_idle"}, 64'(req_ready), 64'd1);
      chk({tag, ":valid_drop"}, 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] got;
      logic [63:0] q_exp[$];
      logic [63:0] a;
      int          acc, nrsp, last;

      // Reset values while held in reset
      repeat (2) @(negedge clk);
      chk("rst:req_ready", 64'(req_ready), 64'd1);
      chk("rst:rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst:rsp_rdata", rsp_rdata, 64'd0);
      chk("rst:rsp_err", 64'(rsp_err), 64'd0);
      rst = 1'b1;

      for (int w = 0; w < 16; w++)
         xact("prefill", 1'b1, 64'(w) * 8, {$urandom, $urandom}, 8'hFF, 0, got);

      // Full write then read back at 0x40
      xact("wr40", 1'b1, 64'h40, 64'h1122334455667788, 8'hFF, 0, got);
      chk("wr40:rdata_zero", got, 64'd0);
      xact("rd40", 1'b0, 64'h40, 64'd0, 8'h00, 0, got);
      chk("rd40:const", got, 64'h1122334455667788);

      // Partial byte-lane writes
      xact("fill40", 1'b1, 64'h40, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, got);
      xact("m01", 1'b1, 64'h40, 64'h00000000000000AB, 8'h01, 0, got);
      xact("m0c", 1'b1, 64'h40, 64'h0000CDEF00000000, 8'h0C, 0, got);
      xact("rdm", 1'b0, 64'h40, 64'd0, 8'hFF, 0, got);
      chk("rdm:const", got, 64'hFFFFFFFF0000FFAB);
      xact("m30", 1'b1, 64'h40, 64'h0000CDEF00000000, 8'h30, 0, got);
      xact("m00", 1'b1, 64'h40, 64'hDEADBEEFDEADBEEF, 8'h00, 0, got);
      xact("rdm2", 1'b0, 64'h43, 64'd0, 8'h00, 0, got);
      chk("rdm2:const", got, 64'hFFFFCDEF0000FFAB);

      // Response held off for 5 cycles
      xact("hold5", 1'b0, 64'h40, 64'd0, 8'h00, 5, got);

      // Reset while a write to word 5 is in flight
      xact("pre5", 1'b1, 64'h28, 64'hA5A5A5A55A5A5A5A, 8'hFF, 0, got);
      xact("rd5a", 1'b0, 64'h28, 64'd0, 8'h00, 0, got);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h28;
      req_wdata = 64'hDEADBEEFCAFEF00D; req_wmask = 8'hFF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstbusy:in_busy", 64'(req_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("rstbusy:req_ready", 64'(req_ready), 64'd1);
      chk("rstbusy:rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rstbusy:rsp_rdata", rsp_rdata, 64'd0);
      chk("rstbusy:rsp_err", 64'(rsp_err), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      xact("rd5b", 1'b0, 64'h28, 64'd0, 8'h00, 0, got);
      chk("rd5b:const", got, 64'hA5A5A5A55A5A5A5A);

      // Address just beyond the array: wraps to word 1 or flags an error
      xact("pre1", 1'b1, 64'h8, 64'h0102030405060708, 8'hFF, 0, got);
      xact("rd2008", 1'b0, 64'h2008, 64'd0, 8'h00, 0, got);
      xact("wr2008", 1'b1, 64'h2008, 64'hFEEDFACE12345678, 8'hFF, 0, got);
      xact("rd8", 1'b0, 64'h8, 64'd0, 8'h00, 0, got);

      // Back-to-back reads with req_valid and rsp_ready held high
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_wmask = 8'h00;
      req_addr = 64'($urandom_range(0, 15)) * 8;
      rsp_ready = 1'b1;
      acc = 0; nrsp = 0; last = -1;
      for (int c = 0; c < 5 * (LATENCY + 2); c++) begin
         if (c > 0) @(negedge clk);
         if (rsp_valid === 1'b1) begin
            nrsp++;
            if (q_exp.size() > 0) chk("b2b:rdata", rsp_rdata, q_exp.pop_front());
            else chk("b2b:unexpected_rsp", 64'(q_exp.size()), 64'd1);
            req_addr = 64'($urandom_range(0, 15)) * 8;
         end
         if (req_ready === 1'b1) begin
            if (last >= 0) chk("b2b:gap", 64'(c - last), 64'(LATENCY + 2));
            last = c;
            acc++;
            q_exp.push_back(mdl_word(req_addr));
         end
         if (c == 5 * (LATENCY + 2) - 1) req_valid = 1'b0;
      end
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("b2b:accepts", 64'(acc), 64'd5);
      chk("b2b:responses", 64'(nrsp), 64'd5);

      // Randomized mix including aliased addresses
      for (int n = 0; n < 40; n++) begin
         a = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) a = a + 64'($urandom_range(1, 7)) * 64'(DEPTH) * 8;
         xact("rand", 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
              8'($urandom), int'($urandom_range(0, 2)), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
